alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, minimum 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set present.
REQ-005 SHALL have port in_ready  output  1  block accepts operand set this cycle.
REQ-006 SHALL have port A  input  WIDTH  operand A.
REQ-007 SHALL have port B  input  WIDTH  operand B.
REQ-008 SHALL have port MODE  input  3  operation select.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port Y  output  WIDTH+1  result; Y[WIDTH] is carry/borrow.
REQ-012 SHALL have port flags  output  4  {neg, ovf, zero, carry} of Y.

Function
REQ-013 SHALL accept an input when in_valid && in_ready; Y and flags of that input SHALL appear with out_valid exactly 2 cycles later when no stall occurs.
REQ-014 SHALL be two stages, S1 (operand register) and S2 (result register); S2 loads when empty or out_ready; S1 loads when empty or S2 loads.
REQ-015 in_ready SHALL equal !s1_valid || s2_load, combinational from current state and out_ready.
REQ-016 While out_valid && !out_ready, Y, flags and out_valid SHALL hold stable; no transaction dropped or duplicated.
REQ-017 Full throughput: with out_ready held 1, one result per cycle.
REQ-018 MODE 0: Y = A + B, zero-extended to WIDTH+1 bits.
REQ-019 MODE 1: Y = A - B modulo 2^(WIDTH+1); Y[WIDTH]=1 iff A < B unsigned.
REQ-020 MODE 2: Y = A + 1; MODE 3: Y = B + 1.
REQ-021 MODE 4 (accumulate): Y = ACC + A; ACC <= Y[WIDTH-1:0] when result loads into S2.
REQ-022 MODE 5/6/7: Y = {0, A&B} / {0, A|B} / {0, A^B}.
REQ-023 ACC SHALL be an internal WIDTH-bit register read and written only in S2, so back-to-back MODE 4 inputs chain correctly without stalls.
REQ-024 carry = Y[WIDTH]; zero = (Y[WIDTH-1:0] == 0); neg = Y[WIDTH-1].
REQ-025 ovf = signed two's-complement overflow for MODEs 0-4 (MODE 1 uses subtraction rule); ovf = 0 for MODEs 5-7.
REQ-026 Wrap-around: ACC wraps modulo 2^WIDTH; carry-out reported only in that result's flags.

Reset
REQ-027 rstn low SHALL immediately clear s1_valid, out_valid, ACC, Y and flags to 0, including mid-transaction; in-flight operands are discarded.
REQ-028 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-029 Package alu_pkg SHALL hold mode constants (MODE_ADD..MODE_XOR) and flag bit indices.
REQ-030 Combinational sub-module alu_core (WIDTH, A, B, ACC, MODE -> Y, flags) SHALL be instantiated in S2.
REQ-031 Implementation SHALL use no latches and no clock gating.

Verification (WIDTH=8)
REQ-032 A=0x0F, B=0x01, MODE 0, out_ready=1 -> cycle+2: Y=0x010, flags zero=0 carry=0 ovf=0.
REQ-033 A=0x03, B=0x05, MODE 1 -> Y=0x1FE, carry=1, neg=1; A=0x80, B=0x01, MODE 1 -> Y=0x07F, ovf=1.
REQ-034 MODE 4 with A=0x80 three times back-to-back after reset -> Y=0x080, 0x100 (zero=1, carry=1), 0x080; ACC ends 0x80.
REQ-035 Stream of 6 inputs with out_ready low for 3 cycles mid-stream -> in_ready drops after S1 and S2 fill; Y held stable; all 6 results in order, none lost.
REQ-036 rstn asserted with both stages valid -> out_valid=0 and Y=0 same cycle; first MODE 4 with A=0x01 after release -> Y=0x001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-stage ALU pipeline: operation codes and
// bit positions inside the 4-bit flags word {neg, ovf, zero, carry}.
package alu_pkg;

  typedef enum logic [2:0] {
    MODE_ADD  = 3'd0,
    MODE_SUB  = 3'd1,
    MODE_INCA = 3'd2,
    MODE_INCB = 3'd3,
    MODE_ACC  = 3'd4,
    MODE_AND  = 3'd5,
    MODE_OR   = 3'd6,
    MODE_XOR  = 3'd7
  } alu_mode_e;

  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_NEG   = 3;

endpackage

// File: rtl/alu_pipe_if.sv
// Handshake/data bundle of alu_pipe: master drives operands and out_ready,
// slave (the pipeline) drives in_ready and the result side.
interface alu_pipe_if #(parameter int unsigned WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       MODE;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   Y;
  logic [3:0]       flags;

  modport master (
    output in_valid, A, B, MODE, out_ready,
    input  in_ready, out_valid, Y, flags
  );

  modport slave (
    input  in_valid, A, B, MODE, out_ready,
    output in_ready, out_valid, Y, flags
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: WIDTH+1-bit result (top bit carry/borrow) and
// {neg, ovf, zero, carry} flags; ACC is the accumulator operand for MODE_ACC.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] ACC,
  input  logic [2:0]       MODE,
  output logic [WIDTH:0]   Y,
  output logic [3:0]       flags
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic ovf;

  always_comb begin
    Y   = '0;
    ovf = 1'b0;
    case (alu_mode_e'(MODE))
      MODE_ADD: begin
        Y   = {1'b0, A} + {1'b0, B};
        ovf = (A[WIDTH-1] == B[WIDTH-1]) && (Y[WIDTH-1] != A[WIDTH-1]);
      end
      MODE_SUB: begin
        Y   = {1'b0, A} - {1'b0, B};
        ovf = (A[WIDTH-1] != B[WIDTH-1]) && (Y[WIDTH-1] != A[WIDTH-1]);
      end
      // Increment is addition of +1, so overflow only from max positive.
      MODE_INCA: begin
        Y   = {1'b0, A} + ONE;
        ovf = !A[WIDTH-1] && Y[WIDTH-1];
      end
      MODE_INCB: begin
        Y   = {1'b0, B} + ONE;
        ovf = !B[WIDTH-1] && Y[WIDTH-1];
      end
      MODE_ACC: begin
        Y   = {1'b0, ACC} + {1'b0, A};
        ovf = (ACC[WIDTH-1] == A[WIDTH-1]) && (Y[WIDTH-1] != ACC[WIDTH-1]);
      end
      MODE_AND: Y = {1'b0, A & B};
      MODE_OR:  Y = {1'b0, A | B};
      MODE_XOR: Y = {1'b0, A ^ B};
      default:  Y = '0;
    endcase
  end

  always_comb begin
    flags             = '0;
    flags[FLAG_CARRY] = Y[WIDTH];
    flags[FLAG_ZERO]  = (Y[WIDTH-1:0] == '0);
    flags[FLAG_OVF]   = ovf;
    flags[FLAG_NEG]   = Y[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 registers operands, S2 computes and
// registers the result; the accumulator lives in S2 so MODE_ACC chains per cycle.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MODE,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Y,
  output logic [3:0]       flags
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_mode_e        s1_mode;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   core_y;
  logic [3:0]       core_flags;
  logic             s2_adv;
  logic             s2_load;

  // S2 may advance when empty or drained; it only captures when S1 holds data.
  assign s2_adv   = !out_valid || out_ready;
  assign s2_load  = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_ADD;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= A;
        s1_b    <= B;
        s1_mode <= alu_mode_e'(MODE);
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .A     (s1_a),
    .B     (s1_b),
    .ACC   (acc),
    .MODE  (s1_mode),
    .Y     (core_y),
    .flags (core_flags)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      Y         <= '0;
      flags     <= '0;
      acc       <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Y     <= core_y;
        flags <= core_flags;
        if (s1_mode == MODE_ACC) begin
          acc <= core_y[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): arithmetic reference model plus an in-order
// expectation queue checked every cycle, and directed literal cases.
module tb_alu_pipe;

  localparam int W = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  alu_pipe_if #(.WIDTH(W)) bus();

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .A         (bus.A),
    .B         (bus.B),
    .MODE      (bus.MODE),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .Y         (bus.Y),
    .flags     (bus.flags)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Returns {neg, ovf, zero, carry, y[8:0]} from plain integer arithmetic.
  function automatic logic [12:0] model(input int a, input int b, input int m, input int acc);
    int r, sr;
    int sa, sb, sacc;
    logic ovf;
    logic [8:0] yv;
    sa   = (a   > 127) ? a   - 256 : a;
    sb   = (b   > 127) ? b   - 256 : b;
    sacc = (acc > 127) ? acc - 256 : acc;
    r  = 0;
    sr = 0;
    case (m)
      0: begin r = a + b;   sr = sa + sb;   end
      1: begin r = a - b;   if (r < 0) r += 512; sr = sa - sb; end
      2: begin r = a + 1;   sr = sa + 1;    end
      3: begin r = b + 1;   sr = sb + 1;    end
      4: begin r = acc + a; sr = sacc + sa; end
      5: r = a & b;
      6: r = a | b;
      default: r = a ^ b;
    endcase
    ovf = (m <= 4) && (sr > 127 || sr < -128);
    yv  = r[8:0];
    return {((r % 256) >= 128), ovf, ((r % 256) == 0), (r >= 256), yv};
  endfunction

  typedef struct { logic [8:0] y; logic [3:0] f; int cyc; } exp_t;
  typedef struct { logic [8:0] y; logic [3:0] f; } res_t;

  exp_t q[$];
  res_t got_q[$];
  int   model_acc = 0;
  int   cyc       = 0;
  int   saw_not_ready = 0;

  logic       prev_stall = 1'b0;
  logic [8:0] prev_y;
  logic [3:0] prev_f;
  exp_t       e;
  logic [12:0] mres;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      check("reset_out_valid", 32'(bus.out_valid), 0);
      check("reset_y", 32'(bus.Y), 0);
      check("reset_flags", 32'(bus.flags), 0);
      q.delete();
      model_acc  = 0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
      if (!bus.in_ready) saw_not_ready = 1;
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_y", 32'(bus.Y), 32'(prev_y));
        check("stall_flags", 32'(bus.flags), 32'(prev_f));
      end
      if (q.size() == 0) check("no_spurious", 32'(bus.out_valid), 0);
      else if (cyc >= q[0].cyc + 2) check("latency", 32'(bus.out_valid), 1);
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        e = q.pop_front();
        check("result_y", 32'(bus.Y), 32'(e.y));
        check("result_flags", 32'(bus.flags), 32'(e.f));
        got_q.push_back('{y: bus.Y, f: bus.flags});
      end
      if (bus.in_valid && bus.in_ready) begin
        mres = model(int'(bus.A), int'(bus.B), int'(bus.MODE), model_acc);
        if (bus.MODE == 3'd4) model_acc = int'(mres[7:0]);
        q.push_back('{y: mres[8:0], f: mres[12:9], cyc: cyc});
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y     = bus.Y;
      prev_f     = bus.flags;
    end
  end

  int di_a[$], di_b[$], di_m[$];

  task automatic add_item(input int a, input int b, input int m);
    di_a.push_back(a);
    di_b.push_back(b);
    di_m.push_back(m);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", q.size(), 0);
  endtask

  // stall_mode: 0 = out_ready high, 1 = random gaps/stalls, 2 = 3-cycle stall at cycle 2.
  task automatic run_stream(input int stall_mode, output int cycles);
    int i = 0;
    int c = 0;
    int n;
    logic acc;
    n = di_a.size();
    got_q.delete();
    @(posedge clk); #1;
    while (i < n && c < 2000) begin
      bus.in_valid  = (stall_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.A         = 8'(di_a[i]);
      bus.B         = 8'(di_b[i]);
      bus.MODE      = 3'(di_m[i]);
      bus.out_ready = (stall_mode == 1) ? ($urandom_range(0, 2) != 0) :
                      (stall_mode == 2) ? !(c >= 2 && c < 5) : 1'b1;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      c++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycles = c;
    check("stream_accepted", i, n);
    drain();
    check("stream_results", got_q.size(), n);
    di_a.delete(); di_b.delete(); di_m.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check("ready_after_reset", 32'(bus.in_ready), 1);
  endtask

  int cycles;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0; bus.MODE = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("ready_after_reset", 32'(bus.in_ready), 1);

    // Exact 2-cycle latency: 0x0F + 0x01
    bus.in_valid = 1'b1; bus.A = 8'h0F; bus.B = 8'h01; bus.MODE = 3'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("lat_cycle1_valid", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", 32'(bus.out_valid), 1);
    check("add_lit_y", 32'(bus.Y), 32'h010);
    check("add_lit_flags", 32'(bus.flags), 32'h0);
    drain();

    // Subtraction literals
    add_item(8'h03, 8'h05, 1);
    add_item(8'h80, 8'h01, 1);
    run_stream(0, cycles);
    if (got_q.size() == 2) begin
      check("sub_borrow_y", 32'(got_q[0].y), 32'h1FE);
      check("sub_borrow_flags", 32'(got_q[0].f), 32'b1001);
      check("sub_ovf_y", 32'(got_q[1].y), 32'h07F);
      check("sub_ovf_flags", 32'(got_q[1].f), 32'b0100);
    end

    // Accumulator chaining and wrap
    do_reset();
    add_item(8'h80, 0, 4);
    add_item(8'h80, 0, 4);
    add_item(8'h80, 0, 4);
    add_item(8'h00, 0, 4);
    run_stream(0, cycles);
    check("acc_no_stall_cycles", cycles, 4);
    if (got_q.size() == 4) begin
      check("acc1_y", 32'(got_q[0].y), 32'h080);
      check("acc1_flags", 32'(got_q[0].f), 32'b1000);
      check("acc2_y", 32'(got_q[1].y), 32'h100);
      check("acc2_flags", 32'(got_q[1].f), 32'b0111);
      check("acc3_y", 32'(got_q[2].y), 32'h080);
      check("acc_final_y", 32'(got_q[3].y), 32'h080);
    end

    // Six inputs with a 3-cycle consumer stall mid-stream
    saw_not_ready = 0;
    for (int i = 0; i < 6; i++)
      add_item(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
    run_stream(2, cycles);
    check("stall_backpressure_seen", saw_not_ready, 1);

    // Full throughput
    for (int i = 0; i < 20; i++)
      add_item(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
    run_stream(0, cycles);
    check("throughput_cycles", cycles, 20);

    // Random traffic with random gaps and stalls
    for (int i = 0; i < 300; i++)
      add_item(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
    run_stream(1, cycles);

    // Reset with both stages full
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.A = 8'h55; bus.B = 8'h33; bus.MODE = 3'd4;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("full_before_reset", 32'(bus.out_valid), 1);
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("reset_async_valid", 32'(bus.out_valid), 0);
    check("reset_async_y", 32'(bus.Y), 0);
    check("reset_async_flags", 32'(bus.flags), 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("ready_after_reset", 32'(bus.in_ready), 1);
    add_item(8'h01, 8'h00, 4);
    run_stream(0, cycles);
    if (got_q.size() == 1) begin
      check("acc_after_reset_y", 32'(got_q[0].y), 32'h001);
      check("acc_after_reset_flags", 32'(got_q[0].f), 32'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
